// File: rtl/commit_event_sequencer.sv
// Orders commit records and trap events into one checker-side stream through a small FIFO.
// Optional statistics counters are enabled with the COMMIT_SEQ_STATS_EN macro.
module commit_event_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_inst,
  input  logic                     event_valid,
  input  logic [31:0]              event_cause,
  input  logic [31:0]              event_pc,
  input  logic [31:0]              event_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_kind,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_cause,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef COMMIT_SEQ_STATS_EN
  ,
  output logic [31:0]              commit_count,
  output logic [31:0]              event_count,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cause;
  } rec_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW-1:0] n_push;
  rec_t          mem [DEPTH];
  rec_t          head;
  rec_t          ev_rec;
  rec_t          cm_rec;
  rec_t          rec0;
  logic          any_in;
  logic          accept;
  logic          we0;
  logic          we1;
  logic          pop;

  assign level     = wr_ptr - rd_ptr;
  assign in_ready  = (PW'(DEPTH) - level) >= PW'(2);
  assign out_valid = (state == RUN) && (level != '0);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign wr_ptr_p1 = wr_ptr + PW'(1);

  // Head fields are gated so they read 0 whenever nothing valid is presented.
  assign out_kind  = out_valid & head.kind;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_inst  = out_valid ? head.inst  : '0;
  assign out_cause = out_valid ? head.cause : '0;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ev_rec       = '0;
    ev_rec.kind  = 1'b1;
    ev_rec.pc    = event_pc;
    ev_rec.inst  = event_inst;
    ev_rec.cause = event_cause;
    cm_rec       = '0;
    cm_rec.pc    = commit_pc;
    cm_rec.inst  = commit_inst;
    any_in       = commit_valid | event_valid;
    accept       = (state == RUN) && in_ready;
    we0          = accept && any_in;
    we1          = accept && commit_valid && event_valid;
    rec0         = event_valid ? ev_rec : cm_rec;
    pop          = out_valid && out_ready;
    n_push       = PW'(we0) + PW'(we1);
  end

  // NOTE: the storage array has no reset; validity is carried entirely by the pointers.
  always_ff @(posedge clock) begin
    if (we0) mem[wr_ptr[AW-1:0]] <= rec0;
    if (we1) mem[wr_ptr_p1[AW-1:0]] <= cm_rec;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == RUN && any_in && !in_ready) begin
        overflow <= 1'b1;
        state    <= HALTED;
      end
      wr_ptr <= wr_ptr + n_push;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef COMMIT_SEQ_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      commit_count <= '0;
      event_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop && !head.kind) commit_count <= commit_count + 32'd1;
      if (pop && head.kind)  event_count  <= event_count + 32'd1;
      if (state == RUN && !in_ready) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_event_sequencer.sv
// Self-checking bench for commit_event_sequencer: vector table plus scoreboard of expected records.
// Statistics checks are compiled in when COMMIT_SEQ_STATS_EN is defined.
module tb_commit_event_sequencer;

  localparam int DEPTH = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   commit_valid;
  logic [31:0]            commit_pc;
  logic [31:0]            commit_inst;
  logic                   event_valid;
  logic [31:0]            event_cause;
  logic [31:0]            event_pc;
  logic [31:0]            event_inst;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_kind;
  logic [31:0]            out_pc;
  logic [31:0]            out_inst;
  logic [31:0]            out_cause;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;
`ifdef COMMIT_SEQ_STATS_EN
  logic [31:0]            commit_count;
  logic [31:0]            event_count;
  logic [31:0]            stall_cycles;
`endif

  commit_event_sequencer #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .event_valid  (event_valid),
    .event_cause  (event_cause),
    .event_pc     (event_pc),
    .event_inst   (event_inst),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_kind     (out_kind),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_cause    (out_cause),
    .overflow     (overflow),
    .level        (level)
`ifdef COMMIT_SEQ_STATS_EN
    ,
    .commit_count (commit_count),
    .event_count  (event_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cause;
  } rec_t;

  typedef struct {
    logic        cv;
    logic        ev;
    logic [31:0] cpc;
    logic [31:0] cinst;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] ecause;
    logic        rdy;
    logic [2:0]  lvl;
    logic        ir;
    logic        vld;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_commit = 0;
  int   m_event  = 0;
  int   m_stall  = 0;
  rec_t sb[$];
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cv, input logic ev,
                              input logic [31:0] cpc, input logic [31:0] cinst,
                              input logic [31:0] epc, input logic [31:0] einst,
                              input logic [31:0] ecause, input logic rdy,
                              input logic [2:0] lvl, input logic ir, input logic vld);
    vec_t v;
    v.cv = cv; v.ev = ev; v.cpc = cpc; v.cinst = cinst;
    v.epc = epc; v.einst = einst; v.ecause = ecause;
    v.rdy = rdy; v.lvl = lvl; v.ir = ir; v.vld = vld;
    return v;
  endfunction

  // Scoreboard: every handshake pops the oldest expected record.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        rec_t e;
        e = sb.pop_front();
        check("out_kind", 32'(out_kind), 32'(e.kind));
        check("out_pc", out_pc, e.pc);
        check("out_inst", out_inst, e.inst);
        check("out_cause", out_cause, e.cause);
        if (e.kind) m_event++;
        else        m_commit++;
      end
    end
    if (!reset && !overflow && !in_ready) m_stall++;
  end

  task automatic apply(input vec_t v, input string tag);
    commit_valid = v.cv;
    commit_pc    = v.cpc;
    commit_inst  = v.cinst;
    event_valid  = v.ev;
    event_pc     = v.epc;
    event_inst   = v.einst;
    event_cause  = v.ecause;
    out_ready    = v.rdy;
    if (v.ev) sb.push_back({1'b1, v.epc, v.einst, v.ecause});
    if (v.cv) sb.push_back({1'b0, v.cpc, v.cinst, 32'h0});
    @(posedge clock);
    #1;
    check({tag, "_level"}, 32'(level), 32'(v.lvl));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(v.ir));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(v.vld));
  endtask

  task automatic idle_inputs();
    commit_valid = 1'b0;
    event_valid  = 1'b0;
    commit_pc    = '0;
    commit_inst  = '0;
    event_pc     = '0;
    event_inst   = '0;
    event_cause  = '0;
  endtask

  // Asserts reset between edges and checks the cleared state before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    sb.delete();
    m_commit = 0;
    m_event  = 0;
    m_stall  = 0;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_pc"}, out_pc, 32'd0);
    check({tag, "_out_cause"}, out_cause, 32'd0);
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    idle_inputs();

    vecs[0]  = mk(1, 0, 32'h8000_0000, 32'h0000_0013, 0, 0, 0, 1, 1, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[2]  = mk(1, 1, 32'h8000_0004, 32'h0010_0093, 32'h8000_0004, 32'hFFFF_FFFF, 2, 1, 2, 1, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[5]  = mk(1, 0, 32'h8000_1000, 32'h0000_0a01, 0, 0, 0, 0, 1, 1, 1);
    vecs[6]  = mk(1, 0, 32'h8000_1004, 32'h0000_0a02, 0, 0, 0, 0, 2, 1, 1);
    vecs[7]  = mk(1, 0, 32'h8000_1008, 32'h0000_0a03, 0, 0, 0, 0, 3, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[11] = mk(1, 1, 32'h8000_2004, 32'h0000_0b01, 32'h8000_2000, 32'h0000_0b00, 8, 1, 2, 1, 1);
    vecs[12] = mk(1, 0, 32'h8000_2008, 32'h0000_0b02, 0, 0, 0, 1, 2, 1, 1);
    vecs[13] = mk(1, 1, 32'h8000_2014, 32'h0000_0b04, 32'h8000_2010, 32'h0000_0b03, 11, 1, 3, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_kind", 32'(out_kind), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_cause", out_cause, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Fill to level 3 with the checker stalled; the head must hold steady.
    apply(mk(1, 0, 32'h8000_3000, 32'h0000_0c01, 0, 0, 0, 0, 1, 1, 1), "fill0");
    apply(mk(1, 0, 32'h8000_3004, 32'h0000_0c02, 0, 0, 0, 0, 2, 1, 1), "fill1");
    check("hold_out_pc1", out_pc, 32'h8000_3000);
    apply(mk(1, 0, 32'h8000_3008, 32'h0000_0c03, 0, 0, 0, 0, 3, 0, 1), "fill2");
    check("hold_out_pc2", out_pc, 32'h8000_3000);

    // A commit while in_ready is low is dropped and halts the sequencer.
    commit_valid = 1'b1;
    commit_pc    = 32'hDEAD_0000;
    commit_inst  = 32'hDEAD_0001;
    @(posedge clock);
    #1;
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_out_valid", 32'(out_valid), 32'd0);
    check("ovf_level", 32'(level), 32'd3);
    idle_inputs();
    out_ready   = 1'b1;
    event_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("halt%0d_overflow", i), 32'(overflow), 32'd1);
      check($sformatf("halt%0d_out_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("halt%0d_level", i), 32'(level), 32'd3);
    end
    async_reset("rst_halt");

    // Reset in the middle of a burst discards everything buffered.
    apply(mk(1, 0, 32'h8000_4000, 32'h0000_0d01, 0, 0, 0, 0, 1, 1, 1), "burst0");
    apply(mk(1, 0, 32'h8000_4004, 32'h0000_0d02, 0, 0, 0, 0, 2, 1, 1), "burst1");
    apply(mk(1, 0, 32'h8000_4008, 32'h0000_0d03, 0, 0, 0, 0, 3, 0, 1), "burst2");
    async_reset("rst_burst");

    // Post-reset traffic: 5 commits and 2 events, first commit must be the head.
    apply(mk(1, 0, 32'h1234_5678, 32'h0000_0e01, 0, 0, 0, 1, 1, 1, 1), "post0");
    apply(mk(1, 1, 32'h1234_5680, 32'h0000_0e03, 32'h1234_567c, 32'h0000_0e02, 5, 1, 2, 1, 1), "post1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1), "post2");
    apply(mk(1, 1, 32'h1234_5688, 32'h0000_0e05, 32'h1234_5684, 32'h0000_0e04, 7, 1, 2, 1, 1), "post3");
    apply(mk(1, 0, 32'h1234_568c, 32'h0000_0e06, 0, 0, 0, 1, 2, 1, 1), "post4");
    apply(mk(1, 0, 32'h1234_5690, 32'h0000_0e07, 0, 0, 0, 1, 2, 1, 1), "post5");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1), "post6");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "post7");
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

`ifdef COMMIT_SEQ_STATS_EN
    check("commit_count", commit_count, 32'(m_commit));
    check("event_count", event_count, 32'(m_event));
    check("stall_cycles", stall_cycles, 32'(m_stall));
    check("commit_total", 32'(m_commit), 32'd5);
    check("event_total", 32'(m_event), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
